// File: rtl/mem_exception_commit_if.sv
`default_nettype none
// ============================================================================
//  Module      : mem_exception_commit_pkg / mem_exception_commit_if
//  Description : Shared exception-flag type and the bus interface between
//                the EXE/MEM boundary, the CP0 update port and the fetch
//                redirect port of mem_exception_commit.
//                master : EXE-side / environment driver (EXE_*, MEM_Stall,
//                         CP0_EPC, IF_RedirectAck out; MEM/CP0 results in)
//                slave  : mem_exception_commit itself
//  Revision    : 1.0 - initial release
// ============================================================================

package mem_exception_commit_pkg;

  // Merged EXE exception flags, listed from highest to lowest priority.
  typedef struct packed {
    logic interrupt;
    logic wrong_address_in_if;
    logic tlb_refill_in_if;
    logic tlb_invalid_in_if;
    logic coprocessor_unusable;
    logic reserved_instruction;
    logic overflow;
    logic trap;
    logic syscall;
    logic break_exc;
    logic rd_wrong_address_in_mem;
    logic wr_wrong_address_in_mem;
    logic rd_tlb_refill_in_mem;
    logic wr_tlb_refill_in_mem;
    logic rd_tlb_invalid_in_mem;
    logic wr_tlb_invalid_in_mem;
    logic tlb_modified;
    logic eret;
    logic refetch;
  } except_in_pipe_t;

endpackage

interface mem_exception_commit_if;
  import mem_exception_commit_pkg::*;

  // EXE stage inputs
  logic            EXE_Valid;
  except_in_pipe_t EXE_ExceptType_final;
  logic [31:0]     EXE_PC;
  logic [31:0]     EXE_ALUOut;
  logic            EXE_IsInDelaySlot;
  logic            MEM_Stall;
  logic [31:0]     CP0_EPC;
  logic            IF_RedirectAck;

  // MEM / redirect / CP0 results
  logic            MEM_Valid;
  logic            MEM_Flush;
  logic [31:0]     MEM_RedirectPC;
  logic            CP0_ExcWr;
  logic [4:0]      CP0_ExcCode;
  logic [31:0]     CP0_EPCOut;
  logic            CP0_BD;
  logic            CP0_BadVAddrWr;
  logic [31:0]     CP0_BadVAddr;
  logic            CP0_EretWr;

  modport master (
    output EXE_Valid, EXE_ExceptType_final, EXE_PC, EXE_ALUOut,
           EXE_IsInDelaySlot, MEM_Stall, CP0_EPC, IF_RedirectAck,
    input  MEM_Valid, MEM_Flush, MEM_RedirectPC, CP0_ExcWr, CP0_ExcCode,
           CP0_EPCOut, CP0_BD, CP0_BadVAddrWr, CP0_BadVAddr, CP0_EretWr
  );

  modport slave (
    input  EXE_Valid, EXE_ExceptType_final, EXE_PC, EXE_ALUOut,
           EXE_IsInDelaySlot, MEM_Stall, CP0_EPC, IF_RedirectAck,
    output MEM_Valid, MEM_Flush, MEM_RedirectPC, CP0_ExcWr, CP0_ExcCode,
           CP0_EPCOut, CP0_BD, CP0_BadVAddrWr, CP0_BadVAddr, CP0_EretWr
  );

endinterface

`default_nettype wire

// File: rtl/mem_exception_commit.sv
`default_nettype none
// ============================================================================
//  Module      : mem_exception_commit
//  Description : MEM-stage exception commit. Registers the EXE exception
//                vector, PC, data address and delay-slot flag, prioritises
//                the flags, issues a one-shot CP0 update (or ERET) request,
//                drives the redirect PC and holds MEM_Flush until fetch
//                acknowledges the redirect.
//  Ports       : clk, rst (async, active-high)
//                bus (mem_exception_commit_if.slave): EXE inputs, MEM_Stall,
//                CP0_EPC, IF_RedirectAck in; MEM_Valid, MEM_Flush,
//                MEM_RedirectPC and CP0_* update request out.
//  Options     : MEM_REFETCH_EN - when defined the Refetch flag flushes and
//                redirects to the MEM PC; when undefined it is ignored.
//  Revision    : 1.0 - initial release
// ============================================================================

module mem_exception_commit
  import mem_exception_commit_pkg::*;
#(
  parameter logic [31:0] EXC_VEC_BASE    = 32'hBFC0_0380,
  parameter logic [31:0] REFILL_VEC_BASE = 32'hBFC0_0200
) (
  input  logic                  clk,
  input  logic                  rst,
  mem_exception_commit_if.slave bus
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam logic [1:0] BADV_NONE = 2'd0;
  localparam logic [1:0] BADV_PC   = 2'd1;
  localparam logic [1:0] BADV_ALU  = 2'd2;

  state_t          state_q, state_d;
  logic            mem_valid_q, mem_valid_d;
  except_in_pipe_t mem_exc_q, mem_exc_d;
  logic [31:0]     mem_pc_q, mem_pc_d;
  logic [31:0]     mem_alu_q, mem_alu_d;
  logic            mem_bd_q, mem_bd_d;
  logic            reported_q, reported_d;
  logic [31:0]     redirect_pc_q, redirect_pc_d;

  except_in_pipe_t exc_live;
  logic            pri_exc;
  logic            pri_eret;
  logic            pri_refetch;
  logic            pri_refill;
  logic [4:0]      pri_code;
  logic [1:0]      pri_badv_sel;
  logic            decision;
  logic            pulse;
  logic            exc_wr;
  logic [31:0]     redirect_calc;

  // Refetch only participates when the feature is built in.
  always_comb begin
`ifdef MEM_REFETCH_EN
    exc_live = mem_exc_q;
`else
    exc_live         = mem_exc_q;
    exc_live.refetch = 1'b0;
`endif
  end

  // Fixed-priority encoder, first match wins.
  always_comb begin
    pri_exc      = 1'b0;
    pri_eret     = 1'b0;
    pri_refetch  = 1'b0;
    pri_refill   = 1'b0;
    pri_code     = 5'd0;
    pri_badv_sel = BADV_NONE;
    if (exc_live.interrupt) begin
      pri_exc = 1'b1; pri_code = 5'd0;
    end else if (exc_live.wrong_address_in_if) begin
      pri_exc = 1'b1; pri_code = 5'd4; pri_badv_sel = BADV_PC;
    end else if (exc_live.tlb_refill_in_if) begin
      pri_exc = 1'b1; pri_code = 5'd2; pri_badv_sel = BADV_PC; pri_refill = 1'b1;
    end else if (exc_live.tlb_invalid_in_if) begin
      pri_exc = 1'b1; pri_code = 5'd2; pri_badv_sel = BADV_PC;
    end else if (exc_live.coprocessor_unusable) begin
      pri_exc = 1'b1; pri_code = 5'd11;
    end else if (exc_live.reserved_instruction) begin
      pri_exc = 1'b1; pri_code = 5'd10;
    end else if (exc_live.overflow) begin
      pri_exc = 1'b1; pri_code = 5'd12;
    end else if (exc_live.trap) begin
      pri_exc = 1'b1; pri_code = 5'd13;
    end else if (exc_live.syscall) begin
      pri_exc = 1'b1; pri_code = 5'd8;
    end else if (exc_live.break_exc) begin
      pri_exc = 1'b1; pri_code = 5'd9;
    end else if (exc_live.rd_wrong_address_in_mem) begin
      pri_exc = 1'b1; pri_code = 5'd4; pri_badv_sel = BADV_ALU;
    end else if (exc_live.wr_wrong_address_in_mem) begin
      pri_exc = 1'b1; pri_code = 5'd5; pri_badv_sel = BADV_ALU;
    end else if (exc_live.rd_tlb_refill_in_mem) begin
      pri_exc = 1'b1; pri_code = 5'd2; pri_badv_sel = BADV_ALU; pri_refill = 1'b1;
    end else if (exc_live.wr_tlb_refill_in_mem) begin
      pri_exc = 1'b1; pri_code = 5'd3; pri_badv_sel = BADV_ALU; pri_refill = 1'b1;
    end else if (exc_live.rd_tlb_invalid_in_mem) begin
      pri_exc = 1'b1; pri_code = 5'd2; pri_badv_sel = BADV_ALU;
    end else if (exc_live.wr_tlb_invalid_in_mem) begin
      pri_exc = 1'b1; pri_code = 5'd3; pri_badv_sel = BADV_ALU;
    end else if (exc_live.tlb_modified) begin
      pri_exc = 1'b1; pri_code = 5'd1; pri_badv_sel = BADV_ALU;
    end else if (exc_live.eret) begin
      pri_eret = 1'b1;
    end else if (exc_live.refetch) begin
      pri_refetch = 1'b1;
    end
  end

  assign decision = (state_q == IDLE) && mem_valid_q && (pri_exc || pri_eret || pri_refetch);
  // A stalled decision cycle repeats; the sticky bit keeps CP0 side effects one-shot.
  assign pulse    = decision && !reported_q;
  assign exc_wr   = pulse && pri_exc;

  always_comb begin
    redirect_calc = EXC_VEC_BASE;
    if (pri_eret) begin
      redirect_calc = bus.CP0_EPC;
    end else if (pri_refetch) begin
      redirect_calc = mem_pc_q;
    end else if (pri_refill) begin
      redirect_calc = REFILL_VEC_BASE;
    end
  end

  // Next-state and MEM register update.
  always_comb begin
    state_d       = state_q;
    mem_valid_d   = mem_valid_q;
    mem_exc_d     = mem_exc_q;
    mem_pc_d      = mem_pc_q;
    mem_alu_d     = mem_alu_q;
    mem_bd_d      = mem_bd_q;
    reported_d    = reported_q;
    redirect_pc_d = redirect_pc_q;

    case (state_q)
      IDLE: begin
        if (decision) begin
          // Latch the target once so a later CP0_EPC change cannot move it.
          if (!reported_q) begin
            redirect_pc_d = redirect_calc;
          end
          if (bus.MEM_Stall) begin
            reported_d = 1'b1;
          end else begin
            reported_d  = 1'b0;
            mem_valid_d = 1'b0;
            mem_exc_d   = '0;
            mem_pc_d    = 32'd0;
            mem_alu_d   = 32'd0;
            mem_bd_d    = 1'b0;
            state_d     = bus.IF_RedirectAck ? IDLE : FLUSH;
          end
        end else if (!bus.MEM_Stall) begin
          mem_valid_d = bus.EXE_Valid;
          mem_exc_d   = bus.EXE_ExceptType_final;
          mem_pc_d    = bus.EXE_PC;
          mem_alu_d   = bus.EXE_ALUOut;
          mem_bd_d    = bus.EXE_IsInDelaySlot;
        end
      end
      FLUSH: begin
        reported_d  = 1'b0;
        mem_valid_d = 1'b0;
        mem_exc_d   = '0;
        mem_pc_d    = 32'd0;
        mem_alu_d   = 32'd0;
        mem_bd_d    = 1'b0;
        if (bus.IF_RedirectAck) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      mem_valid_q   <= 1'b0;
      mem_exc_q     <= '0;
      mem_pc_q      <= 32'd0;
      mem_alu_q     <= 32'd0;
      mem_bd_q      <= 1'b0;
      reported_q    <= 1'b0;
      redirect_pc_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      mem_valid_q   <= mem_valid_d;
      mem_exc_q     <= mem_exc_d;
      mem_pc_q      <= mem_pc_d;
      mem_alu_q     <= mem_alu_d;
      mem_bd_q      <= mem_bd_d;
      reported_q    <= reported_d;
      redirect_pc_q <= redirect_pc_d;
    end
  end

  // Outputs
  assign bus.MEM_Valid      = mem_valid_q;
  assign bus.MEM_Flush      = decision || (state_q == FLUSH);
  assign bus.MEM_RedirectPC = (state_q == FLUSH) ? redirect_pc_q :
                              decision ? (reported_q ? redirect_pc_q : redirect_calc) :
                              32'd0;
  assign bus.CP0_ExcWr      = exc_wr;
  assign bus.CP0_EretWr     = pulse && pri_eret;
  assign bus.CP0_ExcCode    = exc_wr ? pri_code : 5'd0;
  assign bus.CP0_EPCOut     = exc_wr ? (mem_bd_q ? (mem_pc_q - 32'd4) : mem_pc_q) : 32'd0;
  assign bus.CP0_BD         = exc_wr && mem_bd_q;
  assign bus.CP0_BadVAddrWr = exc_wr && (pri_badv_sel != BADV_NONE);
  assign bus.CP0_BadVAddr   = !exc_wr                 ? 32'd0    :
                              (pri_badv_sel == BADV_PC)  ? mem_pc_q  :
                              (pri_badv_sel == BADV_ALU) ? mem_alu_q :
                              32'd0;

endmodule

`default_nettype wire

// File: tb/tb_mem_exception_commit.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_exception_commit
//  Description : Directed self-checking bench for mem_exception_commit.
//                Expected CP0 requests are queued when an instruction is
//                driven and popped when the block issues its pulse.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_mem_exception_commit;
  import mem_exception_commit_pkg::*;

  localparam logic [31:0] EXC_VEC    = 32'hBFC0_0380;
  localparam logic [31:0] REFILL_VEC = 32'hBFC0_0200;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_exception_commit_if bus ();

  mem_exception_commit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        exc_wr;
    logic        eret_wr;
    logic [4:0]  code;
    logic [31:0] epc;
    logic        bd;
    logic        badv_wr;
    logic [31:0] badv;
    logic [31:0] redirect;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   exc_pulses = 0;
  int   eret_pulses = 0;

  always @(posedge clk) begin
    if (!rst && bus.CP0_ExcWr)  exc_pulses++;
    if (!rst && bus.CP0_EretWr) eret_pulses++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input logic exc_wr, input logic eret_wr, input logic [4:0] code,
                          input logic [31:0] epc, input logic bd, input logic badv_wr,
                          input logic [31:0] badv, input logic [31:0] redirect);
    exp_t e;
    e.exc_wr = exc_wr; e.eret_wr = eret_wr; e.code = code; e.epc = epc;
    e.bd = bd; e.badv_wr = badv_wr; e.badv = badv; e.redirect = redirect;
    sb.push_back(e);
  endtask

  // Presents one instruction for a cycle; returns at the negedge where the
  // instruction sits in the MEM registers.
  task automatic drive(input except_in_pipe_t e, input logic valid, input logic [31:0] pc,
                       input logic [31:0] alu, input logic bd);
    @(negedge clk);
    bus.EXE_Valid            = valid;
    bus.EXE_ExceptType_final = e;
    bus.EXE_PC               = pc;
    bus.EXE_ALUOut           = alu;
    bus.EXE_IsInDelaySlot    = bd;
    @(negedge clk);
    bus.EXE_Valid            = 1'b0;
    bus.EXE_ExceptType_final = '0;
    bus.EXE_PC               = 32'd0;
    bus.EXE_ALUOut           = 32'd0;
    bus.EXE_IsInDelaySlot    = 1'b0;
  endtask

  task automatic check_pulse(input string tag);
    exp_t e;
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (bus.CP0_ExcWr || bus.CP0_EretWr) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk({tag, "_pulse_seen"}, {31'd0, seen}, 32'd1);
    chk({tag, "_sb_nonempty"}, {31'd0, (sb.size() != 0)}, 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_excwr"},    {31'd0, bus.CP0_ExcWr},      {31'd0, e.exc_wr});
      chk({tag, "_eretwr"},   {31'd0, bus.CP0_EretWr},     {31'd0, e.eret_wr});
      chk({tag, "_code"},     {27'd0, bus.CP0_ExcCode},    {27'd0, e.code});
      chk({tag, "_epc"},      bus.CP0_EPCOut,              e.epc);
      chk({tag, "_bd"},       {31'd0, bus.CP0_BD},         {31'd0, e.bd});
      chk({tag, "_badvwr"},   {31'd0, bus.CP0_BadVAddrWr}, {31'd0, e.badv_wr});
      chk({tag, "_badv"},     bus.CP0_BadVAddr,            e.badv);
      chk({tag, "_redirect"}, bus.MEM_RedirectPC,          e.redirect);
      chk({tag, "_flush"},    {31'd0, bus.MEM_Flush},      32'd1);
    end
  endtask

  // Counts flush cycles from the current negedge, raising ack in cycle ack_at.
  task automatic finish_flush(input string tag, input int ack_at, input int exp_len,
                              input logic [31:0] exp_pc);
    int   cnt;
    logic stable;
    cnt = 0;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (!bus.MEM_Flush) break;
      cnt++;
      if (bus.MEM_RedirectPC !== exp_pc) stable = 1'b0;
      if (cnt == ack_at) bus.IF_RedirectAck = 1'b1;
      @(negedge clk);
      bus.IF_RedirectAck = 1'b0;
    end
    chk({tag, "_flush_len"}, cnt, exp_len);
    chk({tag, "_redirect_stable"}, {31'd0, stable}, 32'd1);
  endtask

  initial begin
    except_in_pipe_t e;
    int base;

    bus.EXE_Valid            = 1'b0;
    bus.EXE_ExceptType_final = '0;
    bus.EXE_PC               = 32'd0;
    bus.EXE_ALUOut           = 32'd0;
    bus.EXE_IsInDelaySlot    = 1'b0;
    bus.MEM_Stall            = 1'b0;
    bus.CP0_EPC              = 32'd0;
    bus.IF_RedirectAck       = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_valid",    {31'd0, bus.MEM_Valid}, 32'd0);
    chk("rst_flush",    {31'd0, bus.MEM_Flush}, 32'd0);
    chk("rst_excwr",    {31'd0, bus.CP0_ExcWr}, 32'd0);
    chk("rst_redirect", bus.MEM_RedirectPC,     32'd0);
    rst = 1'b0;

    // Plain instruction commits without flush.
    e = '0;
    drive(e, 1'b1, 32'h8000_0000, 32'd0, 1'b0);
    chk("plain_valid", {31'd0, bus.MEM_Valid}, 32'd1);
    chk("plain_flush", {31'd0, bus.MEM_Flush}, 32'd0);

    // Overflow in delay slot, ack in fourth flush cycle.
    e = '0; e.overflow = 1'b1;
    push_exp(1, 0, 5'd12, 32'h8000_0100, 1, 0, 32'd0, EXC_VEC);
    drive(e, 1'b1, 32'h8000_0104, 32'h1234_5678, 1'b1);
    check_pulse("ovf");
    finish_flush("ovf", 4, 4, EXC_VEC);
    chk("ovf_valid_after", {31'd0, bus.MEM_Valid}, 32'd0);

    // Misaligned load, ack in the decision cycle.
    e = '0; e.rd_wrong_address_in_mem = 1'b1;
    push_exp(1, 0, 5'd4, 32'h8000_0200, 0, 1, 32'h1000_0002, EXC_VEC);
    drive(e, 1'b1, 32'h8000_0200, 32'h1000_0002, 1'b0);
    check_pulse("ldmis");
    finish_flush("ldmis", 1, 1, EXC_VEC);

    // Interrupt beats syscall.
    e = '0; e.interrupt = 1'b1; e.syscall = 1'b1;
    push_exp(1, 0, 5'd0, 32'h8000_0500, 0, 0, 32'd0, EXC_VEC);
    drive(e, 1'b1, 32'h8000_0500, 32'h0000_0040, 1'b0);
    check_pulse("int");
    finish_flush("int", 2, 2, EXC_VEC);

    // Fetch TLB refill: refill vector, BadVAddr from PC.
    e = '0; e.tlb_refill_in_if = 1'b1;
    push_exp(1, 0, 5'd2, 32'h8000_0300, 0, 1, 32'h8000_0300, REFILL_VEC);
    drive(e, 1'b1, 32'h8000_0300, 32'hDEAD_0000, 1'b0);
    check_pulse("itlbr");
    finish_flush("itlbr", 2, 2, REFILL_VEC);

    // Store TLB refill outranks TLB modified.
    e = '0; e.wr_tlb_refill_in_mem = 1'b1; e.tlb_modified = 1'b1;
    push_exp(1, 0, 5'd3, 32'h8000_03FC, 1, 1, 32'h0040_1000, REFILL_VEC);
    drive(e, 1'b1, 32'h8000_0400, 32'h0040_1000, 1'b1);
    check_pulse("stlbr");
    finish_flush("stlbr", 1, 1, REFILL_VEC);

    // ERET redirects to CP0_EPC with no exception write.
    bus.CP0_EPC = 32'h8000_2000;
    e = '0; e.eret = 1'b1;
    push_exp(0, 1, 5'd0, 32'd0, 0, 0, 32'd0, 32'h8000_2000);
    drive(e, 1'b1, 32'h8000_0800, 32'd0, 1'b0);
    check_pulse("eret");
    finish_flush("eret", 1, 1, 32'h8000_2000);

    // Flags on an invalid slot are ignored.
    e = '0; e.overflow = 1'b1;
    drive(e, 1'b0, 32'h8000_0900, 32'd0, 1'b0);
    chk("inval_flush", {31'd0, bus.MEM_Flush}, 32'd0);
    chk("inval_excwr", {31'd0, bus.CP0_ExcWr}, 32'd0);

    // Syscall with MEM_Stall held 5 cycles: one pulse only.
    base = exc_pulses;
    e = '0; e.syscall = 1'b1;
    push_exp(1, 0, 5'd8, 32'h8000_0600, 0, 0, 32'd0, EXC_VEC);
    drive(e, 1'b1, 32'h8000_0600, 32'd0, 1'b0);
    check_pulse("stall");
    bus.MEM_Stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_flush_held", {31'd0, bus.MEM_Flush}, 32'd1);
    end
    bus.MEM_Stall = 1'b0;
    finish_flush("stall", 2, 2, EXC_VEC);
    chk("stall_one_pulse", exc_pulses - base, 1);

    // Refetch behaviour depends on build option.
    e = '0; e.refetch = 1'b1;
    drive(e, 1'b1, 32'h8000_0A00, 32'd0, 1'b0);
`ifdef MEM_REFETCH_EN
    chk("refetch_flush",    {31'd0, bus.MEM_Flush}, 32'd1);
    chk("refetch_redirect", bus.MEM_RedirectPC,     32'h8000_0A00);
    chk("refetch_excwr",    {31'd0, bus.CP0_ExcWr}, 32'd0);
    finish_flush("refetch", 1, 1, 32'h8000_0A00);
`else
    chk("refetch_flush",  {31'd0, bus.MEM_Flush}, 32'd0);
    chk("refetch_valid",  {31'd0, bus.MEM_Valid}, 32'd1);
    chk("refetch_excwr",  {31'd0, bus.CP0_ExcWr}, 32'd0);
`endif

    // Reset while in FLUSH.
    e = '0; e.break_exc = 1'b1;
    push_exp(1, 0, 5'd9, 32'h8000_0700, 0, 0, 32'd0, EXC_VEC);
    drive(e, 1'b1, 32'h8000_0700, 32'd0, 1'b0);
    check_pulse("brk");
    @(negedge clk);
    chk("brk_in_flush", {31'd0, bus.MEM_Flush}, 32'd1);
    chk("brk_bubble",   {31'd0, bus.MEM_Valid}, 32'd0);
    rst = 1'b1;
    #1;
    chk("rstf_flush",    {31'd0, bus.MEM_Flush}, 32'd0);
    chk("rstf_valid",    {31'd0, bus.MEM_Valid}, 32'd0);
    chk("rstf_redirect", bus.MEM_RedirectPC,     32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rstf_idle_flush", {31'd0, bus.MEM_Flush}, 32'd0);

    chk("sb_empty",    sb.size(), 0);
    chk("exc_total",   exc_pulses, 7);
    chk("eret_total",  eret_pulses, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
